// File: rtl/pe_accumulator.sv
// Running-sum register for the PE adder tree; final group sums queue in a DEPTH-entry FIFO (1-cycle last-beat-to-out_valid).
// Backpressure: pe_ready drops when the FIFO is full, decided from registered state only (never from out_ready).
module pe_accumulator #(
  parameter int SUM_W = 20,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] pe_sum_in,
  input  logic             pe_valid,
  input  logic             pe_last,
  output logic             pe_ready,
  output logic [SUM_W-1:0] previous_sum,
  output logic [SUM_W-1:0] out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = SUM_W + CNT_W + 1;

  typedef enum logic {IDLE, ACCUM} grp_t;

  grp_t             state_q, state_d;
  logic [SUM_W-1:0] acc_q;
  logic [CNT_W-1:0] beat_q;
  logic             ovf_q;
  logic             rdy_en_q;

  logic             first_q;
  logic             accept;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] delta;
  logic             ovf_beat;
  logic [CNT_W-1:0] beat_inc;
  logic [ENT_W-1:0] push_ent;
  logic [ENT_W-1:0] head_ent;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;

  assign first_q      = (state_q == IDLE);
  assign previous_sum = first_q ? '0 : acc_q;

  // rdy_en_q holds pe_ready low until the first clock edge after reset release.
  assign pe_ready = rdy_en_q && (count < (AW+1)'(DEPTH));
  assign accept   = pe_valid && pe_ready;
  assign push     = accept && pe_last;
  assign pop      = out_valid && out_ready;

  assign delta    = pe_sum_in - previous_sum;
  assign ovf_beat = (previous_sum[SUM_W-1] == delta[SUM_W-1]) &&
                    (pe_sum_in[SUM_W-1] != previous_sum[SUM_W-1]);
  assign beat_inc = (beat_q == {CNT_W{1'b1}}) ? beat_q : beat_q + CNT_W'(1);
  assign push_ent = {pe_sum_in, beat_inc, ovf_q | ovf_beat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = pe_last ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (accept) begin
        if (pe_last) begin
          acc_q  <= '0;
          beat_q <= '0;
          ovf_q  <= 1'b0;
        end else begin
          acc_q  <= pe_sum_in;
          beat_q <= beat_inc;
          ovf_q  <= ovf_q | ovf_beat;
        end
      end
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign head_ent  = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = head_ent[ENT_W-1 -: SUM_W];
  assign out_beats = head_ent[CNT_W:1];
  assign out_ovf   = head_ent[0];

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed bench for pe_accumulator: adder-tree model drives beats, a scoreboard checks FIFO results.
module tb_pe_accumulator;

  localparam int SUM_W = 20;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [SUM_W-1:0] pe_sum_in;
  logic             pe_valid;
  logic             pe_last;
  logic             pe_ready;
  logic [SUM_W-1:0] previous_sum;
  logic [SUM_W-1:0] out_data;
  logic [CNT_W-1:0] out_beats;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready;

  always #5 clk = ~clk;

  pe_accumulator #(.SUM_W(SUM_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pe_sum_in    (pe_sum_in),
    .pe_valid     (pe_valid),
    .pe_last      (pe_last),
    .pe_ready     (pe_ready),
    .previous_sum (previous_sum),
    .out_data     (out_data),
    .out_beats    (out_beats),
    .out_ovf      (out_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  typedef struct packed {
    logic [SUM_W-1:0] d;
    logic [CNT_W-1:0] b;
    logic             o;
  } res_t;

  res_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [SUM_W-1:0] m_prev  = '0;
  logic [CNT_W-1:0] m_beats = '0;
  logic             m_ovf   = 1'b0;
  logic [SUM_W-1:0] cur_p;
  logic             cur_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = '0;
    m_beats = '0;
    m_ovf   = 1'b0;
  endtask

  // Called at a negedge: present a beat built by the adder-tree model.
  task automatic start_beat(input logic [SUM_W-1:0] p, input logic last);
    @(negedge clk);
    check("previous_sum", 32'(previous_sum), 32'(m_prev));
    cur_p     = p;
    cur_last  = last;
    pe_sum_in = m_prev + p;
    pe_last   = last;
    pe_valid  = 1'b1;
  endtask

  // Called at a negedge with a beat presented: hold it until accepted.
  task automatic finish_beat();
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] nb;
    logic             ob;
    int               n = 0;
    while (!pe_ready) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        check("pe_ready_timeout", 32'(pe_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    pe_valid = 1'b0;
    pe_last  = 1'b0;
    sum = m_prev + cur_p;
    ob  = (m_prev[SUM_W-1] == cur_p[SUM_W-1]) && (sum[SUM_W-1] != m_prev[SUM_W-1]);
    nb  = (m_beats == {CNT_W{1'b1}}) ? m_beats : m_beats + CNT_W'(1);
    if (cur_last) begin
      sb.push_back('{d: sum, b: nb, o: m_ovf | ob});
      model_reset();
    end else begin
      m_prev  = sum;
      m_beats = nb;
      m_ovf   = m_ovf | ob;
    end
  endtask

  task automatic beat(input logic [SUM_W-1:0] p, input logic last);
    start_beat(p, last);
    finish_beat();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks head stability under stall.
  logic             stalled = 1'b0;
  logic [SUM_W-1:0] hd_d;
  logic [CNT_W-1:0] hd_b;
  logic             hd_o;

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        check("stall_data", 32'(out_data), 32'(hd_d));
        check("stall_beats", 32'(out_beats), 32'(hd_b));
        check("stall_ovf", 32'(out_ovf), 32'(hd_o));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_beats", 32'(out_beats), 32'(e.b));
          check("out_ovf", 32'(out_ovf), 32'(e.o));
        end
      end
      stalled = out_valid && !out_ready;
      hd_d    = out_data;
      hd_b    = out_beats;
      hd_o    = out_ovf;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    pe_valid  = 1'b0;
    pe_last   = 1'b0;
    pe_sum_in = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pe_ready", 32'(pe_ready), 32'd0);
    check("rst_prev_sum", 32'(previous_sum), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_pe_ready", 32'(pe_ready), 32'd0);
    @(posedge clk);
    #1;
    check("first_edge_pe_ready", 32'(pe_ready), 32'd1);
    out_ready = 1'b1;

    // Single three-beat group with latency check
    beat(SUM_W'(100), 1'b0);
    beat(SUM_W'(150), 1'b0);
    start_beat(SUM_W'(-60), 1'b1);
    check("pre_last_out_valid", 32'(out_valid), 32'd0);
    finish_beat();
    check("latency_out_valid", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back single-beat groups
    beat(SUM_W'(7), 1'b1);
    beat(SUM_W'(-3), 1'b1);
    drain();

    // Signed overflow and flag clearing
    beat(SUM_W'(20'h7FFFF), 1'b0);
    beat(SUM_W'(1), 1'b1);
    beat(SUM_W'(5), 1'b1);
    drain();

    // Backpressure with full FIFO
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    beat(SUM_W'(5), 1'b1);
    beat(SUM_W'(6), 1'b1);
    start_beat(SUM_W'(7), 1'b1);
    check("bp_pe_ready", 32'(pe_ready), 32'd0);
    check("bp_head", 32'(out_data), 32'd5);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_ready", 32'(pe_ready), 32'd0);
      check("bp_hold_head", 32'(out_data), 32'd5);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("full_pop_ready", 32'(pe_ready), 32'd0);
    finish_beat();
    drain();

    // Bubbles every 4th cycle (some with a stray pe_last) and beat-count saturation
    for (int i = 1; i <= 300; i++) begin
      beat(SUM_W'(1), i == 300);
      if (i % 3 == 0 && i < 300) begin
        pe_last = (i % 2 == 0);
        @(posedge clk);
        #1;
        pe_last = 1'b0;
        check("bubble_hold", 32'(previous_sum), 32'(m_prev));
      end
    end
    drain();

    // Reset mid-group with a queued result
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    beat(SUM_W'(9), 1'b1);
    beat(SUM_W'(10), 1'b0);
    beat(SUM_W'(20), 1'b0);
    @(negedge clk);
    check("pre_rst_prev_sum", 32'(previous_sum), 32'(m_prev));
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_prev_sum", 32'(previous_sum), 32'd0);
    check("mid_rst_pe_ready", 32'(pe_ready), 32'd0);
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    beat(SUM_W'(4), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_accumulator.md
Name: pe_accumulator

Overview:
Output-side partner of the PE adder tree. It takes the per-cycle PE_sum, registers it as the running partial, and drives it back as previous_sum. When the producer marks the last beat of a dot-product group, it captures the final sum into a small output FIFO. Results leave through a valid/ready handshake, so downstream stalls back-pressure the PE array.

Parameters:
SUM_W, 20, width of pe_sum_in / previous_sum / out_data (matches PE_sum)
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_W, 8, width of per-group beat counter (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pe_sum_in  in  SUM_W  PE_sum from adder tree (partials + previous_sum)
pe_valid  in  1  pe_sum_in valid this cycle
pe_last  in  1  beat is last of current group (qualified by pe_valid)
pe_ready  out  1  block accepts a beat this cycle
previous_sum  out  SUM_W  running partial fed back to adder tree
out_data  out  SUM_W  FIFO head: final group sum
out_beats  out  CNT_W  FIFO head: beats in group (saturating)
out_ovf  out  1  FIFO head: signed overflow occurred in group
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head

Behaviour:
- Reset (async, rst_n=0): acc_q=0, first_q=1, beat_q=0, ovf_q=0, FIFO empty. out_valid=0, pe_ready=0, previous_sum=0, out_data/out_beats/out_ovf=0. After release: pe_ready=1 on the first clock edge.
- Accept = pe_valid & pe_ready.
- pe_ready = (fifo_count < DEPTH).
  - Registered-state only; no combinational path from out_ready.
  - Full + pop in same cycle: pe_ready stays 0 that cycle.
- previous_sum = first_q ? 0 : acc_q. Combinational from registers only, never from pe_sum_in.
- delta = pe_sum_in - previous_sum (SUM_W wrap).
- ovf_beat = previous_sum[MSB]==delta[MSB] && pe_sum_in[MSB]!=previous_sum[MSB].
- Accept, pe_last=0:
  - acc_q<=pe_sum_in, first_q<=0.
  - beat_q<=sat(beat_q+1).
  - ovf_q<=ovf_q|ovf_beat.
- Accept, pe_last=1:
  - Push {pe_sum_in, sat(beat_q+1), ovf_q|ovf_beat}.
  - acc_q<=0, first_q<=1, beat_q<=0, ovf_q<=0.
- No accept: all accumulator state holds. pe_valid low mid-group is a legal bubble.
- sat(): clamps at 2^CNT_W-1; no wrap.
- Arithmetic: SUM_W two's-complement, modulo 2^SUM_W. Overflow is flagged, never saturated.
- FIFO:
  - Pop = out_valid & out_ready. out_* reflect the head, stable while out_valid & !out_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- Latency: last beat accepted at edge N with FIFO empty → out_valid=1 after edge N, so it is observable in the following cycle.
- Group state machine:
  - IDLE (first_q=1) → ACCUM on a non-last accept.
  - IDLE → IDLE on a last accept (single-beat group).
  - ACCUM → IDLE on a last accept.
- Reset mid-group or with FIFO full: all partial and queued results are discarded. No output is produced for them.
- pe_last with pe_valid=0 is ignored.

Test Plan:
- Single group: bench models adder (pe_sum_in = previous_sum + p), p = 100, 150, -60, last on third. → previous_sum seen 0, 100, 250; out_data=190, out_beats=3, out_ovf=0; out_valid one cycle after the last accept.
- Single-beat groups back-to-back, p=7 then p=-3 (each last), out_ready=1. → previous_sum=0 on both beats; outputs 7 then 0xFFFFD, out_beats=1 each.
- Overflow: p=0x7FFFF then p=1 (last). → out_data=0x80000, out_ovf=1; next group p=5 (last) gives out_ovf=0.
- Backpressure: out_ready=0, single-beat groups 5, 6, 7 presented continuously. → 5 and 6 accepted, pe_ready=0, 7 held. Raise out_ready: outputs 5, 6, 7 in order, no loss or duplication. out_* stable while stalled.
- Bubbles and saturation: 300 beats of p=1 with pe_valid low every 4th cycle, last on beat 300. → out_data=300, out_beats=255.
- Reset mid-operation: two beats (p=10, 20) accepted plus one result queued, then rst_n low 2 cycles. → out_valid=0, previous_sum=0, pe_ready=0 during reset. Next group p=4 (last) yields 4 with out_beats=1.
